// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and optional first-word-fall-through reads.
module sync_fifo #(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 4,
  parameter int AFULL_THR  = (1 << ASIZE) - 2,
  parameter int AEMPTY_THR = 2,
  parameter bit FWFT       = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] AFULL_V  = (ASIZE+1)'(AFULL_THR);
  localparam logic [ASIZE:0] AEMPTY_V = (ASIZE+1)'(AEMPTY_THR);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr, rptr;
  logic [ASIZE-1:0] waddr, raddr;
  logic             wr_en, rd_en;

  assign waddr = wptr[ASIZE-1:0];
  assign raddr = rptr[ASIZE-1:0];

  // Flags come purely from the registered pointers, so they are stable all cycle.
  assign count         = wptr - rptr;
  assign rempty        = (wptr == rptr);
  assign wfull         = (wptr[ASIZE] != rptr[ASIZE]) && (waddr == raddr);
  assign walmost_full  = (count >= AFULL_V);
  assign ralmost_empty = (count <= AEMPTY_V);

  assign wr_en = winc & ~wfull;
  assign rd_en = rinc & ~rempty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  // A new error event on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc & wfull)   overflow <= 1'b1;
      else if (err_clr)   overflow <= 1'b0;
      if (rinc & rempty)  underflow <= 1'b1;
      else if (err_clr)   underflow <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign rdata = mem[raddr];
    end else begin : g_std
      logic [DSIZE-1:0] rdata_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        rdata_q <= '0;
        else if (rd_en) rdata_q <= mem[raddr];
      end
      assign rdata = rdata_q;
    end
  endgenerate

endmodule
